// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA raster timing generator with a hex readout decoder.
//            Divides clk down to a pixel strobe, walks the (h,v) raster in
//            active / front porch / sync / back porch order, and emits sync,
//            blanking and per-pixel "readout cell" decode for a row of glyph
//            cells showing "0x" followed by NUM_DIGITS hex nibbles of value.
// Ports    : clk          system clock
//            rst          asynchronous, active-low reset
//            value        number shown in the readout (4*NUM_DIGITS bits)
//            vga_clk      50% duty pixel clock
//            pix_en       one-clk strobe per pixel period
//            hsync/vsync  active-low syncs
//            bright       active-area flag (vga_blank_n is the same value)
//            hcount/vcount pixel coordinates aligned with the decode outputs
//            frame_start  one-clk pulse on the first clk of pixel (0,0)
//            main, gbval  inside-cell flag and glyph code of that cell
//            x_start/x_end/y_start/y_end  current cell bounds (end exclusive)
//            rgb_color    cell colour
// Options  : define VGA_FRAME_LATCH_EN to sample value once per frame (at
//            frame_start) so the readout never tears mid-frame.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          CLK_DIV    = 2,
  parameter int          MAIN_X     = 272,
  parameter int          MAIN_Y     = 175,
  parameter int          GLYPH_W    = 64,
  parameter int          GLYPH_H    = 64,
  parameter int          NUM_DIGITS = 2,
  parameter logic [23:0] TEXT_COLOR = 24'h343a40
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value,
  output logic                      vga_clk,
  output logic                      pix_en,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      bright,
  output logic                      vga_blank_n,
  output logic [9:0]                hcount,
  output logic [9:0]                vcount,
  output logic                      frame_start,
  output logic                      main,
  output logic [4:0]                gbval,
  output logic [9:0]                x_start,
  output logic [9:0]                x_end,
  output logic [9:0]                y_start,
  output logic [9:0]                y_end,
  output logic [23:0]               rgb_color
);

  localparam int                 c_div_w    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV / 2);

  localparam int         c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
  localparam logic [9:0] c_h_act    = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_act    = 10'(V_ACTIVE);
  localparam logic [9:0] c_hs_beg   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_beg   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] c_y_beg    = 10'(MAIN_Y);
  localparam logic [9:0] c_y_end    = 10'(MAIN_Y + GLYPH_H);
  localparam int         c_cells    = NUM_DIGITS + 2;

  // --------------------------------------------------------------------------
  // Pixel-rate divider
  // --------------------------------------------------------------------------
  logic [c_div_w-1:0] r_div_cnt;
  logic [c_div_w-1:0] w_div_nxt;
  logic               r_vga_clk;

  assign w_div_nxt = (r_div_cnt == c_div_last) ? '0 : r_div_cnt + 1'b1;

  // The strobe is a decode of the registered counter, so it is high for
  // exactly the clk in which the counter sits at its last value.
  assign pix_en  = (r_div_cnt == c_div_last);
  assign vga_clk = r_vga_clk;

  // vga_clk is registered from the next counter value so that it always
  // equals (div_cnt >= CLK_DIV/2) for the current counter value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_vga_clk <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_vga_clk <= (w_div_nxt >= c_div_half);
    end
  end

  // --------------------------------------------------------------------------
  // Raster position
  // --------------------------------------------------------------------------
  logic [9:0] r_h;
  logic [9:0] r_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (pix_en) begin
      if (r_h == c_h_last) begin
        r_h <= '0;
        r_v <= (r_v == c_v_last) ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // r_new_pix is high in the first clk after (h,v) moved; it comes out of
  // reset set so the first clk after release counts as entering (0,0).
  logic r_new_pix;
  logic w_fs_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_new_pix <= 1'b1;
    else      r_new_pix <= pix_en;
  end

  assign w_fs_nxt = (r_h == 10'd0) && (r_v == 10'd0) && r_new_pix;

  // --------------------------------------------------------------------------
  // Source of the displayed number
  // --------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] w_val;

`ifdef VGA_FRAME_LATCH_EN
  logic [4*NUM_DIGITS-1:0] r_val_q;

  // Sampled on the same edge that raises frame_start; held for the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_val_q <= '0;
    else if (w_fs_nxt) r_val_q <= value;
  end

  assign w_val = r_val_q;
`else
  assign w_val = value;
`endif

  // --------------------------------------------------------------------------
  // Glyph code per cell: "0", "x", then nibbles MS-first
  // --------------------------------------------------------------------------
  logic [4:0] w_cell_gb [c_cells];

  generate
    for (genvar k = 0; k < c_cells; k++) begin : g_cell
      if (k == 0) begin : g_zero
        assign w_cell_gb[k] = 5'h00;
      end else if (k == 1) begin : g_x
        assign w_cell_gb[k] = 5'h11;
      end else begin : g_digit
        assign w_cell_gb[k] = {1'b0, w_val[4*(NUM_DIGITS-1-(k-2)) +: 4]};
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Combinational decode of the current (h,v)
  // --------------------------------------------------------------------------
  logic       w_bright;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_in_rows;
  logic       w_main;
  logic [4:0] w_gb;
  logic [9:0] w_xs;
  logic [9:0] w_xe;
  logic [9:0] w_ys;
  logic [9:0] w_ye;

  assign w_bright  = (r_h < c_h_act) && (r_v < c_v_act);
  assign w_hsync   = !((r_h >= c_hs_beg) && (r_h < c_hs_end));
  assign w_vsync   = !((r_v >= c_vs_beg) && (r_v < c_vs_end));
  assign w_in_rows = w_bright && (r_v >= c_y_beg) && (r_v < c_y_end);

  always_comb begin
    w_main = 1'b0;
    w_gb   = 5'h00;
    w_xs   = '0;
    w_xe   = '0;
    w_ys   = '0;
    w_ye   = '0;
    if (w_in_rows) begin
      // Cells are disjoint, so at most one of these matches.
      for (int k = 0; k < c_cells; k++) begin
        if ((r_h >= 10'(MAIN_X + k*GLYPH_W)) &&
            (r_h <  10'(MAIN_X + (k+1)*GLYPH_W))) begin
          w_main = 1'b1;
          w_gb   = w_cell_gb[k];
          w_xs   = 10'(MAIN_X + k*GLYPH_W);
          w_xe   = 10'(MAIN_X + (k+1)*GLYPH_W);
          w_ys   = c_y_beg;
          w_ye   = c_y_end;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output registers: one clk behind (h,v), all mutually aligned
  // --------------------------------------------------------------------------
  logic        r_hsync;
  logic        r_vsync;
  logic        r_bright;
  logic [9:0]  r_hcount;
  logic [9:0]  r_vcount;
  logic        r_frame_start;
  logic        r_main;
  logic [4:0]  r_gbval;
  logic [9:0]  r_xs;
  logic [9:0]  r_xe;
  logic [9:0]  r_ys;
  logic [9:0]  r_ye;
  logic [23:0] r_rgb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_bright      <= 1'b0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_frame_start <= 1'b0;
      r_main        <= 1'b0;
      r_gbval       <= '0;
      r_xs          <= '0;
      r_xe          <= '0;
      r_ys          <= '0;
      r_ye          <= '0;
      r_rgb         <= '0;
    end else begin
      r_hsync       <= w_hsync;
      r_vsync       <= w_vsync;
      r_bright      <= w_bright;
      r_hcount      <= r_h;
      r_vcount      <= r_v;
      r_frame_start <= w_fs_nxt;
      r_main        <= w_main;
      r_gbval       <= w_gb;
      r_xs          <= w_xs;
      r_xe          <= w_xe;
      r_ys          <= w_ys;
      r_ye          <= w_ye;
      r_rgb         <= w_main ? TEXT_COLOR : 24'h000000;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign bright      = r_bright;
  assign vga_blank_n = r_bright;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign frame_start = r_frame_start;
  assign main        = r_main;
  assign gbval       = r_gbval;
  assign x_start     = r_xs;
  assign x_end       = r_xe;
  assign y_start     = r_ys;
  assign y_end       = r_ye;
  assign rgb_color   = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen using a reduced raster
//            (56 x 27 total, 40 x 20 active) so whole frames are short.
//            Cells: x 8..14 / 14..20 / 20..26 / 26..32, y 5..11.
//            Two instances: CLK_DIV=2 (main checks) and CLK_DIV=4 (divider).
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int c_frame_clks = 56 * 27 * 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] value = 8'hA5;

  always #5 clk = ~clk;

  logic        a_vga_clk, a_pix_en, a_hsync, a_vsync, a_bright, a_blank_n;
  logic [9:0]  a_hcount, a_vcount, a_xs, a_xe, a_ys, a_ye;
  logic        a_frame_start, a_main;
  logic [4:0]  a_gbval;
  logic [23:0] a_rgb;

  logic        b_vga_clk, b_pix_en, b_hsync, b_vsync, b_bright, b_blank_n;
  logic [9:0]  b_hcount, b_vcount, b_xs, b_xe, b_ys, b_ye;
  logic        b_frame_start, b_main;
  logic [4:0]  b_gbval;
  logic [23:0] b_rgb;

  vga_timing_gen #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(2), .MAIN_X(8), .MAIN_Y(5), .GLYPH_W(6), .GLYPH_H(6),
    .NUM_DIGITS(2), .TEXT_COLOR(24'h343a40)
  ) dut2 (
    .clk(clk), .rst(rst), .value(value),
    .vga_clk(a_vga_clk), .pix_en(a_pix_en), .hsync(a_hsync), .vsync(a_vsync),
    .bright(a_bright), .vga_blank_n(a_blank_n), .hcount(a_hcount), .vcount(a_vcount),
    .frame_start(a_frame_start), .main(a_main), .gbval(a_gbval),
    .x_start(a_xs), .x_end(a_xe), .y_start(a_ys), .y_end(a_ye), .rgb_color(a_rgb)
  );

  vga_timing_gen #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(4), .MAIN_X(8), .MAIN_Y(5), .GLYPH_W(6), .GLYPH_H(6),
    .NUM_DIGITS(2), .TEXT_COLOR(24'h343a40)
  ) dut4 (
    .clk(clk), .rst(rst), .value(value),
    .vga_clk(b_vga_clk), .pix_en(b_pix_en), .hsync(b_hsync), .vsync(b_vsync),
    .bright(b_bright), .vga_blank_n(b_blank_n), .hcount(b_hcount), .vcount(b_vcount),
    .frame_start(b_frame_start), .main(b_main), .gbval(b_gbval),
    .x_start(b_xs), .x_end(b_xe), .y_start(b_ys), .y_end(b_ye), .rgb_color(b_rgb)
  );

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    int         x;
    int         y;
    logic       bright;
    logic       hs;
    logic       vs;
    logic       main;
    logic [4:0] gb;
    logic [9:0] xs;
    logic [9:0] xe;
    logic [9:0] ys;
    logic [9:0] ye;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
    end
  endtask

  // Advance to the first sampled clk showing pixel (x,y) on dut2.
  task automatic goto_pix(input int x, input int y);
    bit hit = 1'b0;
    for (int i = 0; i < 7000 && !hit; i++) begin
      @(negedge clk);
      if (a_hcount == 10'(x) && a_vcount == 10'(y)) hit = 1'b1;
    end
    chk($sformatf("reach(%0d,%0d)", x, y), 32'(hit), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".pix_en"},  32'(a_pix_en), 0);
    chk({tag, ".vga_clk"}, 32'(a_vga_clk), 0);
    chk({tag, ".hsync"},   32'(a_hsync), 1);
    chk({tag, ".vsync"},   32'(a_vsync), 1);
    chk({tag, ".bright"},  32'(a_bright), 0);
    chk({tag, ".blank_n"}, 32'(a_blank_n), 0);
    chk({tag, ".hcount"},  32'(a_hcount), 0);
    chk({tag, ".vcount"},  32'(a_vcount), 0);
    chk({tag, ".fstart"},  32'(a_frame_start), 0);
    chk({tag, ".main"},    32'(a_main), 0);
    chk({tag, ".gbval"},   32'(a_gbval), 0);
    chk({tag, ".bounds"},  {a_xs[7:0], a_xe[7:0], a_ys[7:0], a_ye[7:0]}, 0);
    chk({tag, ".rgb"},     32'(a_rgb), 0);
    chk({tag, ".d4.sync"}, {30'd0, b_hsync, b_vsync}, 32'd3);
    chk({tag, ".d4.pix"},  32'(b_pix_en), 0);
  endtask

  // Release rst at a negedge and follow the first eight clks.
  task automatic release_seq(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".pix0"},   32'(a_pix_en), 0);
    chk({tag, ".d4.pix0"}, 32'(b_pix_en), 0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("%s.pix[%0d]", tag, i),     32'(a_pix_en),  32'((i % 2) == 1));
      chk($sformatf("%s.vclk[%0d]", tag, i),    32'(a_vga_clk), 32'((i % 2) == 1));
      chk($sformatf("%s.d4.pix[%0d]", tag, i),  32'(b_pix_en),  32'((i % 4) == 3));
      chk($sformatf("%s.d4.vclk[%0d]", tag, i), 32'(b_vga_clk), 32'((i % 4) >= 2));
      if (i == 1) begin
        chk({tag, ".fs_first"},    32'(a_frame_start), 1);
        chk({tag, ".d4.fs_first"}, 32'(b_frame_start), 1);
        chk({tag, ".hv_first"},    {a_hcount[7:0], a_vcount[7:0]}, 0);
      end
      if (i == 2) begin
        chk({tag, ".fs_second"},    32'(a_frame_start), 0);
        chk({tag, ".d4.fs_second"}, 32'(b_frame_start), 0);
      end
    end
  endtask

  task automatic step_off_pixel();
    logic [9:0] h0 = a_hcount;
    for (int i = 0; i < 4 && a_hcount == h0; i++) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [4:0] exp_c2, exp_c3;

    //          x   y  br hs vs mn  gb     xs  xe  ys  ye
    tbl.push_back('{ 4,  0, 1, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{19,  4, 1, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{ 8,  5, 1, 1, 1, 1, 5'h00,  8, 14,  5, 11});
    tbl.push_back('{13,  5, 1, 1, 1, 1, 5'h00,  8, 14,  5, 11});
    tbl.push_back('{14,  5, 1, 1, 1, 1, 5'h11, 14, 20,  5, 11});
    tbl.push_back('{20,  7, 1, 1, 1, 1, 5'h0A, 20, 26,  5, 11});
    tbl.push_back('{26,  7, 1, 1, 1, 1, 5'h05, 26, 32,  5, 11});
    tbl.push_back('{31,  7, 1, 1, 1, 1, 5'h05, 26, 32,  5, 11});
    tbl.push_back('{32,  7, 1, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{ 7,  8, 1, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{39,  8, 1, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{40,  8, 0, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{43,  8, 0, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{44,  8, 0, 0, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{49,  8, 0, 0, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{50,  8, 0, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{20, 10, 1, 1, 1, 1, 5'h0A, 20, 26,  5, 11});
    tbl.push_back('{20, 11, 1, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{ 0, 19, 1, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{ 0, 20, 0, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{ 0, 21, 0, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{ 0, 22, 0, 1, 0, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{45, 23, 0, 0, 0, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{55, 23, 0, 1, 0, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{ 0, 24, 0, 1, 1, 0, 5'h00,  0,  0,  0,  0});
    tbl.push_back('{55, 25, 0, 1, 1, 0, 5'h00,  0,  0,  0,  0});

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_reset("por");
    release_seq("por");

    // Frame 0: decode table.
    foreach (tbl[i]) begin
      string p = $sformatf("v(%0d,%0d)", tbl[i].x, tbl[i].y);
      goto_pix(tbl[i].x, tbl[i].y);
      chk({p, ".bright"},  32'(a_bright),  32'(tbl[i].bright));
      chk({p, ".blank_n"}, 32'(a_blank_n), 32'(tbl[i].bright));
      chk({p, ".hsync"},   32'(a_hsync),   32'(tbl[i].hs));
      chk({p, ".vsync"},   32'(a_vsync),   32'(tbl[i].vs));
      chk({p, ".main"},    32'(a_main),    32'(tbl[i].main));
      chk({p, ".gbval"},   32'(a_gbval),   32'(tbl[i].gb));
      chk({p, ".x_start"}, 32'(a_xs),      32'(tbl[i].xs));
      chk({p, ".x_end"},   32'(a_xe),      32'(tbl[i].xe));
      chk({p, ".y_start"}, 32'(a_ys),      32'(tbl[i].ys));
      chk({p, ".y_end"},   32'(a_ye),      32'(tbl[i].ye));
      chk({p, ".rgb"},     32'(a_rgb),     tbl[i].main ? 32'h343a40 : 32'h0);
    end

    // Frame wrap: (55,26) -> (0,0) with a one-clk frame_start.
    goto_pix(55, 26);
    step_off_pixel();
    chk("wrap.hv",      {a_hcount[7:0], a_vcount[7:0]}, 0);
    chk("wrap.fs",      32'(a_frame_start), 1);
    @(negedge clk);
    chk("wrap.fs_once", 32'(a_frame_start), 0);
    chk("wrap.hcount2", 32'(a_hcount), 0);
    n = 1;
    while (!a_frame_start && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("frame.period", 32'(n), 32'(c_frame_clks));
    chk("frame.hv",     {a_hcount[7:0], a_vcount[7:0]}, 0);

    // Line wrap: (55,3) -> (0,4).
    goto_pix(55, 3);
    step_off_pixel();
    chk("line.hcount", 32'(a_hcount), 0);
    chk("line.vcount", 32'(a_vcount), 4);

    // Value change mid-frame.
    goto_pix(0, 6);
    value = 8'h3C;
`ifdef VGA_FRAME_LATCH_EN
    exp_c2 = 5'h0A;
    exp_c3 = 5'h05;
`else
    exp_c2 = 5'h03;
    exp_c3 = 5'h0C;
`endif
    goto_pix(20, 7);
    chk("chg.same.c2", 32'(a_gbval), 32'(exp_c2));
    goto_pix(26, 7);
    chk("chg.same.c3", 32'(a_gbval), 32'(exp_c3));
    goto_pix(20, 7);
    chk("chg.next.c2", 32'(a_gbval), 32'h03);
    goto_pix(26, 7);
    chk("chg.next.c3", 32'(a_gbval), 32'h0C);

    // Asynchronous reset inside the sync region.
    goto_pix(46, 23);
    chk("mid.pre_hsync", 32'(a_hsync), 0);
    chk("mid.pre_vsync", 32'(a_vsync), 0);
    #2 rst = 1'b0;
    #1;
    check_reset("mid");
    @(negedge clk);
    check_reset("mid.held");
    release_seq("rel");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
